// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned COUNT_W       = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for an arbitrary WIDTH (at least one bit).
  function automatic int unsigned count_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction of the divisor from the shifted partial remainder.
module div_trial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] a_shifted,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] diff,
  output logic           non_neg
);

  // MSB of the (WIDTH+1)-bit difference is the borrow/sign.
  always_comb begin
    diff    = a_shifted - m;
    non_neg = ~diff[WIDTH];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit
// divisor, one quotient bit per clock, start/busy/done handshake.
// Optional build macro DIV_OVERFLOW_CHECK_EN adds a quotient-overflow
// pre-check that short-circuits to DONE and raises overflow.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned CW = count_width(WIDTH);
  localparam int unsigned AW = WIDTH + 1;

  state_t          state, state_n;
  logic [AW-1:0]   a, a_n;
  logic [AW-1:0]   m, m_n;
  logic [WIDTH-1:0] q, q_n;
  logic [CW-1:0]   count, count_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic            busy_n, done_n, dbz_n;
  logic [AW-1:0]   a_sh, diff, a_step;
  logic [WIDTH-1:0] q_step;
  logic            non_neg;
`ifdef DIV_OVERFLOW_CHECK_EN
  logic            ovf_n;
`endif

  // Shift {A,Q} left by one; A's top bit is always 0 between iterations.
  assign a_sh = AW'({a, q[WIDTH-1]});

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .a_shifted (a_sh),
    .m         (m),
    .diff      (diff),
    .non_neg   (non_neg)
  );

  // Restore on negative trial, otherwise keep the difference and set Q[0].
  assign a_step = non_neg ? diff : a_sh;
  assign q_step = {q[WIDTH-2:0], non_neg};

  // Next-state, datapath and output logic.
  always_comb begin
    state_n     = state;
    a_n         = a;
    m_n         = m;
    q_n         = q;
    count_n     = count;
    quotient_n  = quotient;
    remainder_n = remainder;
    done_n      = 1'b0;
    dbz_n       = div_by_zero;
`ifdef DIV_OVERFLOW_CHECK_EN
    ovf_n       = overflow;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          dbz_n = 1'b0;
`ifdef DIV_OVERFLOW_CHECK_EN
          ovf_n = 1'b0;
`endif
          if (divisor == '0) begin
            dbz_n       = 1'b1;
            quotient_n  = '1;
            remainder_n = dividend[WIDTH-1:0];
            done_n      = 1'b1;
            state_n     = DONE;
          end
`ifdef DIV_OVERFLOW_CHECK_EN
          else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            ovf_n       = 1'b1;
            quotient_n  = '1;
            remainder_n = '0;
            done_n      = 1'b1;
            state_n     = DONE;
          end
`endif
          else begin
            a_n     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_n     = dividend[WIDTH-1:0];
            m_n     = {1'b0, divisor};
            count_n = '0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        a_n     = a_step;
        q_n     = q_step;
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          quotient_n  = q_step;
          remainder_n = a_step[WIDTH-1:0];
          done_n      = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      m           <= '0;
      q           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      m           <= m_n;
      q           <= q_n;
      count       <= count_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
    end
  end

`ifdef DIV_OVERFLOW_CHECK_EN
  // Overflow flag, cleared on accepted start and set by the pre-check.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_n;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
